// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, format codes and the layout of the
// packed decoded record that the decode stage keeps in its FIFO.
package riscv_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // Record layout, LSB first: illegal, fmt, rd, rs2, rs1, funct7, funct3, op, imm, pc.
  localparam int REC_ILL_LSB  = 0;
  localparam int REC_FMT_LSB  = 1;
  localparam int REC_RD_LSB   = 4;
  localparam int REC_RS2_LSB  = 9;
  localparam int REC_RS1_LSB  = 14;
  localparam int REC_F7_LSB   = 19;
  localparam int REC_F3_LSB   = 26;
  localparam int REC_OP_LSB   = 29;
  localparam int REC_IMM_LSB  = 36;

  function automatic int rec_pc_lsb(input int xlen);
    return REC_IMM_LSB + xlen;
  endfunction

  function automatic int rec_width(input int xlen);
    return REC_IMM_LSB + 2 * xlen;
  endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator: selects the I/S/B/U/J immediate for the
// given format and sign-extends it to XLEN; R and illegal formats yield zero.
module riscv_imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  fmt_e            i_fmt,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (i_fmt)
      FMT_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_U: w_imm32 = {i_instr[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Every 32-bit immediate already carries its sign in bit 31.
  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered RV32I decode stage: decodes each accepted instruction into a packed
// record and queues it in a DEPTH-entry FIFO. Define DECODE_RV32M_EN to accept RV32M.
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [6:0]               out_op,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_fmt,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = rec_width(XLEN);
  localparam int PC_LSB = rec_pc_lsb(XLEN);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid
  // must not depend on ready, and ready never depends combinationally on the
  // opposite port (in_ready comes from the stored count only).

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_r_base;
  logic            w_r_legal;
  fmt_e            w_fmt;
  logic [6:0]      w_rec_op;
  logic [2:0]      w_rec_f3;
  logic [6:0]      w_rec_f7;
  logic [4:0]      w_rec_rs1;
  logic [4:0]      w_rec_rs2;
  logic [4:0]      w_rec_rd;
  logic [XLEN-1:0] w_imm;
  logic [RW-1:0]   w_rec;

  assign w_op = in_instr[6:0];
  assign w_f3 = in_instr[14:12];
  assign w_f7 = in_instr[31:25];

  // SUB/SRA are the only base R ops using the alternate funct7.
  assign w_r_base = (w_f7 == F7_BASE) ||
                    ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
`ifdef DECODE_RV32M_EN
  assign w_r_legal = w_r_base || (w_f7 == F7_MULDIV);
`else
  assign w_r_legal = w_r_base;
`endif

  always_comb begin
    w_fmt = FMT_ILL;
    if (in_instr[1:0] == 2'b11) begin
      case (w_op)
        OP_OP:                                  w_fmt = w_r_legal ? FMT_R : FMT_ILL;
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:    w_fmt = FMT_I;
        OP_STORE:                               w_fmt = FMT_S;
        OP_BRANCH:                              w_fmt = FMT_B;
        OP_LUI, OP_AUIPC:                       w_fmt = FMT_U;
        OP_JAL:                                 w_fmt = FMT_J;
        default:                                w_fmt = FMT_ILL;
      endcase
    end
  end

  always_comb begin
    w_rec_op  = '0;
    w_rec_f3  = '0;
    w_rec_f7  = '0;
    w_rec_rs1 = '0;
    w_rec_rs2 = '0;
    w_rec_rd  = '0;
    if (w_fmt != FMT_ILL) begin
      w_rec_op = w_op;
    end
    case (w_fmt)
      FMT_R: begin
        w_rec_f3  = w_f3;
        w_rec_f7  = w_f7;
        w_rec_rs1 = in_instr[19:15];
        w_rec_rs2 = in_instr[24:20];
        w_rec_rd  = in_instr[11:7];
      end
      FMT_I: begin
        w_rec_f3  = w_f3;
        w_rec_rs1 = in_instr[19:15];
        w_rec_rd  = in_instr[11:7];
      end
      FMT_S, FMT_B: begin
        w_rec_f3  = w_f3;
        w_rec_rs1 = in_instr[19:15];
        w_rec_rs2 = in_instr[24:20];
      end
      FMT_U, FMT_J: begin
        w_rec_rd  = in_instr[11:7];
      end
      default: ;
    endcase
  end

  riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (in_instr),
    .i_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  assign w_rec = {in_pc, w_imm, w_rec_op, w_rec_f3, w_rec_f7,
                  w_rec_rs1, w_rec_rs2, w_rec_rd, w_fmt, (w_fmt == FMT_ILL)};

  logic [RW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [RW-1:0] w_head;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready && !flush;
  assign w_pop    = !w_empty && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale storage never leaks out: the head reads as all-zero while empty.
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign out_valid   = !w_empty;
  assign out_count   = r_count;
  assign out_pc      = w_head[PC_LSB +: XLEN];
  assign out_imm     = w_head[REC_IMM_LSB +: XLEN];
  assign out_op      = w_head[REC_OP_LSB +: 7];
  assign out_funct3  = w_head[REC_F3_LSB +: 3];
  assign out_funct7  = w_head[REC_F7_LSB +: 7];
  assign out_rs1     = w_head[REC_RS1_LSB +: 5];
  assign out_rs2     = w_head[REC_RS2_LSB +: 5];
  assign out_rd      = w_head[REC_RD_LSB +: 5];
  assign out_fmt     = w_head[REC_FMT_LSB +: 3];
  assign out_illegal = w_head[REC_ILL_LSB];

endmodule
